alu_wb_flags: RTL and testbench
===============================

ALU_WB_FLAGS -- requirements
Module: alu_wb_flags

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports in_valid input 1, in_ready output 1: ALU result handshake; transfer when both high on a clk edge.
REQ-004 SHALL have ports in_dst input 16 (ALU result), in_ov input 1, in_zr input 1, in_ctrl input 4 (`ALU_* code from defines.v), in_rd input 4 (dest register), in_wen input 1 (result written to register file).
REQ-005 SHALL have ports wb_valid output 1, wb_ready input 1, wb_rd output 4, wb_data output 16: register-file write handshake.
REQ-006 SHALL have ports br_valid input 1, br_ready output 1, br_cond input 3: branch evaluation request.
REQ-007 SHALL have ports br_done output 1, br_taken output 1: branch result; flags output 3 as {N,V,Z}.

Function
REQ-008 SHALL buffer writebacks in a 2-entry FIFO of {rd, data}; push on accepted input with in_wen=1; pop on wb_valid && wb_ready.
REQ-009 SHALL drive in_ready = FIFO not full; full FIFO with same-cycle pop still deasserts in_ready (no pass-through).
REQ-010 SHALL drive wb_valid/wb_rd/wb_data from FIFO head; latency push-to-wb_valid = 1 cycle from empty.
REQ-011 SHALL hold wb_rd/wb_data stable while wb_valid && !wb_ready.
REQ-012 SHALL not push accepted inputs with in_wen=0; flag update still applies.
REQ-013 SHALL update flags on accepted input: `ALU_ADD/`ALU_SUB update N=in_dst[15], V=in_ov, Z=in_zr; `ALU_AND/`ALU_NOR/`ALU_SLL/`ALU_SRL/`ALU_SRA update N and Z only, V holds; `ALU_LHB and any other code update nothing.
REQ-014 SHALL decode br_cond: 000 NEQ (!Z), 001 EQ (Z), 010 GT (!Z && !N), 011 LT (N), 100 GTE (Z || !N), 101 LTE (N || Z), 110 OVFL (V), 111 UNCOND (1).
REQ-015 SHALL, on br_valid && br_ready, register br_taken and pulse br_done high for exactly one cycle next cycle; br_taken holds until next br_done.
REQ-016 SHALL accept at most one branch per cycle; br_valid with br_ready low is ignored and must be held by the requester.
REQ-017 SHALL treat simultaneous input accept, wb pop and branch accept as independent, same-cycle events; FIFO count stays unchanged on push+pop.

Reset
REQ-018 SHALL on rst_n low asynchronously clear FIFO (empty), flags=3'b000, wb_valid=0, br_done=0, br_taken=0, in_ready=1 once reset is applied.
REQ-019 SHALL discard all FIFO contents and any in-flight branch result on reset mid-operation; no br_done pulse after reset release until a new branch is accepted.
REQ-020 SHALL drive br_ready=1 and resume normal operation the first clk edge after rst_n rises.

Configuration
REQ-021 SHALL use macro FLAG_FWD_EN to select branch flag source.
REQ-022 With FLAG_FWD_EN defined, branch evaluation SHALL use flags as updated by a same-cycle accepted flag-updating input (combinational forward); br_ready=1 always.
REQ-023 Without FLAG_FWD_EN, br_ready SHALL be 0 in any cycle in_valid && in_ready && in_ctrl is flag-updating; branch evaluates against registered flags only.

Verification
REQ-024 Reset: assert rst_n=0 mid-stream with 2 FIFO entries -> wb_valid=0, flags=000, in_ready=1 immediately.
REQ-025 FIFO fill: 3 back-to-back wen results, wb_ready=0 -> third stalled (in_ready=0 after two); wb_ready=1 -> data drains in order, rd/data unchanged while stalled.
REQ-026 Flags: ADD dst=16'h8000 ov=1 zr=0 -> flags=110; then AND dst=0 zr=1 -> flags=011 (V held); then LHB -> flags=011.
REQ-027 Branch: flags Z=1, br_cond=001 -> br_done pulse next cycle, br_taken=1; br_cond=000 -> br_taken=0; br_cond=111 -> 1.
REQ-028 Collision: SUB with zr=1 accepted same cycle as br_valid br_cond=001, prior Z=0 -> with FLAG_FWD_EN br_taken=1 next cycle; without, br_ready=0 that cycle, accepted next cycle, br_taken=1.
REQ-029 in_wen=0 ADD dst=0 zr=1 -> no wb_valid, Z=1.

Source files
------------

// File: rtl/alu_wb_flags.sv
// rtl/alu_wb_flags.sv - ALU writeback buffer, condition flags and branch evaluator
//
// Purpose:
//   Accepts ALU results on a valid/ready handshake. Results with in_wen set are
//   queued in a 2-entry {rd, data} FIFO and presented to the register file on the
//   wb_* handshake. Every accepted result may update the {N,V,Z} flags according
//   to its ALU operation. Branch requests are evaluated against the flags and
//   answered one cycle later with a single-cycle br_done pulse and a held br_taken.
//
// Configuration macro:
//   FLAG_FWD_EN  defined   : branches see flags forwarded from a same-cycle
//                            flag-updating result; br_ready is always 1.
//                undefined : branches see registered flags only; br_ready drops
//                            for the cycle a flag-updating result is accepted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        ALU result handshake
//   in_dst[15:0]               ALU result value
//   in_ov, in_zr               overflow and zero indications of the result
//   in_ctrl[3:0]               ALU operation code
//   in_rd[3:0], in_wen         destination register, register write enable
//   wb_valid / wb_ready        register file write handshake
//   wb_rd[3:0], wb_data[15:0]  register file write address and data
//   br_valid / br_ready        branch evaluation request handshake
//   br_cond[2:0]               branch condition code
//   br_done, br_taken          branch result pulse and outcome
//   flags[2:0]                 current {N,V,Z}

module alu_wb_flags (
   input  logic        clk,
   input  logic        rst_n,
   // ALU result input
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_dst,
   input  logic        in_ov,
   input  logic        in_zr,
   input  logic [3:0]  in_ctrl,
   input  logic [3:0]  in_rd,
   input  logic        in_wen,
   // register file writeback
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [3:0]  wb_rd,
   output logic [15:0] wb_data,
   // branch evaluation
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [2:0]  br_cond,
   output logic        br_done,
   output logic        br_taken,
   output logic [2:0]  flags
);

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_NOR = 4'h3;
   localparam logic [3:0] ALU_SLL = 4'h4;
   localparam logic [3:0] ALU_SRL = 4'h5;
   localparam logic [3:0] ALU_SRA = 4'h6;
   localparam logic [3:0] ALU_LHB = 4'h7;

   // Branch condition codes
   localparam logic [2:0] BR_NEQ    = 3'b000;
   localparam logic [2:0] BR_EQ     = 3'b001;
   localparam logic [2:0] BR_GT     = 3'b010;
   localparam logic [2:0] BR_LT     = 3'b011;
   localparam logic [2:0] BR_GTE    = 3'b100;
   localparam logic [2:0] BR_LTE    = 3'b101;
   localparam logic [2:0] BR_OVFL   = 3'b110;
   localparam logic [2:0] BR_UNCOND = 3'b111;

   // Flag bit positions within {N,V,Z}
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   // ------------------------------------------------------------------
   // Writeback FIFO
   // ------------------------------------------------------------------
   logic [3:0]  fifo_rd   [2];
   logic [15:0] fifo_data [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic in_accept;
   logic push;
   logic pop;

   // in_ready looks only at occupancy, so a full FIFO never accepts even when
   // the head is leaving in the same cycle; this keeps in_ready off the
   // wb_ready combinational path.
   assign in_ready  = (count != 2'd2);
   assign in_accept = in_valid && in_ready;
   assign push      = in_accept && in_wen;

   assign wb_valid  = (count != 2'd0);
   assign pop       = wb_valid && wb_ready;
   assign wb_rd     = fifo_rd[rd_ptr];
   assign wb_data   = fifo_data[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_rd[0]   <= 4'h0;
         fifo_rd[1]   <= 4'h0;
         fifo_data[0] <= 16'h0000;
         fifo_data[1] <= 16'h0000;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
      end else begin
         if (push) begin
            fifo_rd[wr_ptr]   <= in_rd;
            fifo_data[wr_ptr] <= in_dst;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Flags
   // ------------------------------------------------------------------
   logic       upd_nvz;     // arithmetic ops: N, V and Z
   logic       upd_nz;      // logical/shift ops: N and Z, V holds
   logic       flag_upd;
   logic [2:0] nxt_flags;

   always_comb begin
      upd_nvz = 1'b0;
      upd_nz  = 1'b0;
      case (in_ctrl)
         ALU_ADD, ALU_SUB:                            upd_nvz = 1'b1;
         ALU_AND, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA: upd_nz  = 1'b1;
         ALU_LHB:                                     ;
         default:                                     ;
      endcase
   end

   assign flag_upd = upd_nvz || upd_nz;

   always_comb begin
      nxt_flags = flags;
      if (in_accept && upd_nvz) begin
         nxt_flags = {in_dst[15], in_ov, in_zr};
      end else if (in_accept && upd_nz) begin
         nxt_flags = {in_dst[15], flags[FLAG_V], in_zr};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= 3'b000;
      end else begin
         flags <= nxt_flags;
      end
   end

   // ------------------------------------------------------------------
   // Branch evaluation
   // ------------------------------------------------------------------
   logic [2:0] eval_flags;
   logic       br_accept;
   logic       cond_true;

`ifdef FLAG_FWD_EN
   // Forward the flags a same-cycle result is about to write, so a branch
   // never has to wait behind a flag update.
   assign eval_flags = nxt_flags;
   assign br_ready   = 1'b1;
`else
   // Without forwarding the registered flags would be stale during a
   // flag-updating accept, so the branch is held off for that cycle.
   assign eval_flags = flags;
   assign br_ready   = !(in_accept && flag_upd);
`endif

   assign br_accept = br_valid && br_ready;

   always_comb begin
      cond_true = 1'b0;
      case (br_cond)
         BR_NEQ:    cond_true = !eval_flags[FLAG_Z];
         BR_EQ:     cond_true =  eval_flags[FLAG_Z];
         BR_GT:     cond_true = !eval_flags[FLAG_Z] && !eval_flags[FLAG_N];
         BR_LT:     cond_true =  eval_flags[FLAG_N];
         BR_GTE:    cond_true =  eval_flags[FLAG_Z] || !eval_flags[FLAG_N];
         BR_LTE:    cond_true =  eval_flags[FLAG_N] ||  eval_flags[FLAG_Z];
         BR_OVFL:   cond_true =  eval_flags[FLAG_V];
         BR_UNCOND: cond_true = 1'b1;
         default:   cond_true = 1'b0;
      endcase
   end

   // br_done is high only for the cycle after an accept; br_taken keeps the
   // last outcome until the next accepted branch replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_done  <= 1'b0;
         br_taken <= 1'b0;
      end else begin
         br_done <= br_accept;
         if (br_accept) begin
            br_taken <= cond_true;
         end
      end
   end

endmodule

// File: tb/tb_alu_wb_flags.sv
// tb/tb_alu_wb_flags.sv - scoreboard testbench for alu_wb_flags

module tb_alu_wb_flags;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_SRL = 4'h5;
   localparam logic [3:0] ALU_LHB = 4'h7;
   localparam logic [3:0] ALU_OTHER = 4'hA;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_dst;
   logic        in_ov;
   logic        in_zr;
   logic [3:0]  in_ctrl;
   logic [3:0]  in_rd;
   logic        in_wen;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        br_valid;
   logic        br_ready;
   logic [2:0]  br_cond;
   logic        br_done;
   logic        br_taken;
   logic [2:0]  flags;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  rd;
      logic [15:0] data;
   } wb_t;

   wb_t  wb_q [$];
   logic br_q [$];

   always #5 clk = ~clk;

   alu_wb_flags dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_dst   (in_dst),
      .in_ov    (in_ov),
      .in_zr    (in_zr),
      .in_ctrl  (in_ctrl),
      .in_rd    (in_rd),
      .in_wen   (in_wen),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .br_valid (br_valid),
      .br_ready (br_ready),
      .br_cond  (br_cond),
      .br_done  (br_done),
      .br_taken (br_taken),
      .flags    (flags)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a transfer.
   initial begin
      logic        hold_v;
      logic [3:0]  hold_rd;
      logic [15:0] hold_data;
      wb_t         e;
      logic        eb;
      hold_v = 1'b0;
      hold_rd = '0;
      hold_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               chk("wb_hold_valid", wb_valid, 1);
               chk("wb_hold_rd", wb_rd, hold_rd);
               chk("wb_hold_data", wb_data, hold_data);
            end
            hold_v    = wb_valid && !wb_ready;
            hold_rd   = wb_rd;
            hold_data = wb_data;
            if (wb_valid && wb_ready) begin
               checks++;
               if (wb_q.size() == 0) begin
                  errors++;
                  $display("FAIL wb_unexpected: rd %0h data %0h with nothing expected", wb_rd, wb_data);
               end else begin
                  checks--;
                  e = wb_q.pop_front();
                  chk("wb_rd", wb_rd, e.rd);
                  chk("wb_data", wb_data, e.data);
               end
            end
            if (br_done) begin
               checks++;
               if (br_q.size() == 0) begin
                  errors++;
                  $display("FAIL br_done_unexpected: br_done=1 with no branch outstanding");
               end else begin
                  checks--;
                  eb = br_q.pop_front();
                  chk("br_taken", br_taken, eb);
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [3:0] ctrl, input logic [3:0] rd, input logic [15:0] dst,
                       input logic ov, input logic zr, input logic wen);
      int   n;
      logic acc;
      n = 0;
      in_valid = 1'b1;
      in_ctrl = ctrl;
      in_rd = rd;
      in_dst = dst;
      in_ov = ov;
      in_zr = zr;
      in_wen = wen;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for rd %0h", rd);
      end else if (wen) begin
         wb_q.push_back({rd, dst});
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic branch(input logic [2:0] cond, input logic exp);
      int   n;
      logic acc;
      n = 0;
      br_valid = 1'b1;
      br_cond = cond;
      do begin
         @(negedge clk);
         acc = br_ready;
         @(posedge clk);
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL branch_timeout: br_ready stayed 0 for cond %0b", cond);
      end else begin
         br_q.push_back(exp);
      end
      #1 br_valid = 1'b0;
   endtask

   // Hand-computed branch outcomes for flags {N,V,Z} = 001
   logic [2:0] br_tab_cond [8] = '{3'b001, 3'b000, 3'b111, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
   logic       br_tab_exp  [8] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};

   initial begin
      logic acc_b;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_dst = '0;
      in_ov = 1'b0;
      in_zr = 1'b0;
      in_ctrl = '0;
      in_rd = '0;
      in_wen = 1'b0;
      wb_ready = 1'b0;
      br_valid = 1'b0;
      br_cond = '0;

      #1;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_flags", flags, 3'b000);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_br_done", br_done, 0);
      chk("rst_br_taken", br_taken, 0);
      #21 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("br_ready_after_rst", br_ready, 1);

      // FIFO fill: third result stalls, drains in order once wb_ready rises
      send(ALU_LHB, 4'h1, 16'hA001, 1'b0, 1'b0, 1'b1);
      chk("wb_latency", wb_valid, 1);
      send(ALU_LHB, 4'h2, 16'hA002, 1'b0, 1'b0, 1'b1);
      chk("in_ready_full", in_ready, 0);
      fork
         begin
            repeat (3) @(posedge clk);
            #1 wb_ready = 1'b1;
            @(negedge clk);
            chk("no_passthrough", in_ready, 0);
         end
      join_none
      send(ALU_LHB, 4'h3, 16'hA003, 1'b0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("fifo_drained", wb_valid, 0);

      // Flag updates
      send(ALU_ADD, 4'h0, 16'h8000, 1'b1, 1'b0, 1'b0);
      chk("flags_add", flags, 3'b110);
      send(ALU_AND, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("flags_and_vhold", flags, 3'b011);
      send(ALU_LHB, 4'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      chk("flags_lhb", flags, 3'b011);
      send(ALU_OTHER, 4'h0, 16'h8000, 1'b0, 1'b0, 1'b0);
      chk("flags_other", flags, 3'b011);
      send(ALU_SRL, 4'h0, 16'h8000, 1'b0, 1'b0, 1'b0);
      chk("flags_srl_vhold", flags, 3'b110);

      // in_wen=0 updates flags but writes nothing back
      send(ALU_ADD, 4'h5, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("flags_wen0", flags, 3'b001);
      chk("wen0_no_wb", wb_valid, 0);

      // Branch conditions against flags = 001
      for (int i = 0; i < 8; i++) begin
         branch(br_tab_cond[i], br_tab_exp[i]);
      end
      repeat (2) @(posedge clk);
      #1;

      // Collision: SUB zr=1 with EQ branch in the same cycle, prior Z=0
      send(ALU_ADD, 4'h0, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("flags_pre_collision", flags, 3'b000);
      in_valid = 1'b1;
      in_ctrl = ALU_SUB;
      in_dst = 16'h0000;
      in_ov = 1'b0;
      in_zr = 1'b1;
      in_wen = 1'b0;
      br_valid = 1'b1;
      br_cond = 3'b001;
      @(negedge clk);
      chk("collision_in_ready", in_ready, 1);
`ifdef FLAG_FWD_EN
      chk("collision_br_ready", br_ready, 1);
`else
      chk("collision_br_ready", br_ready, 0);
`endif
      acc_b = br_ready;
      @(posedge clk);
      if (acc_b) br_q.push_back(1'b1);
      #1 in_valid = 1'b0;
      if (!acc_b) begin
         @(negedge clk);
         chk("collision_br_ready_next", br_ready, 1);
         @(posedge clk);
         br_q.push_back(1'b1);
         #1;
      end
      br_valid = 1'b0;
      chk("flags_sub", flags, 3'b001);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-stream with two FIFO entries and a branch result in flight
      wb_ready = 1'b0;
      send(ALU_LHB, 4'h7, 16'hB007, 1'b0, 1'b0, 1'b1);
      send(ALU_LHB, 4'h8, 16'hB008, 1'b0, 1'b0, 1'b1);
      branch(3'b111, 1'b1);
      rst_n = 1'b0;
      wb_q.delete();
      br_q.delete();
      #1;
      chk("midrst_wb_valid", wb_valid, 0);
      chk("midrst_flags", flags, 3'b000);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_br_done", br_done, 0);
      chk("midrst_br_taken", br_taken, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wb_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("postrst_wb_valid", wb_valid, 0);
      chk("postrst_br_ready", br_ready, 1);

      // Resume normal operation
      send(ALU_SUB, 4'h9, 16'hC009, 1'b1, 1'b0, 1'b1);
      chk("flags_resume", flags, 3'b110);
      branch(3'b110, 1'b1);
      branch(3'b000, 1'b1);

      repeat (5) @(posedge clk);
      #1;
      chk("wb_q_empty", wb_q.size(), 0);
      chk("br_q_empty", br_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
